// File: rtl/imem_ld_pkg.sv
// rtl/imem_ld_pkg.sv - shared types and constants for the instruction-memory loader
package imem_ld_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_LO,
        ST_HI,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         BYTES_PER_WORD = 2;
    localparam int         DATA_W_DEF     = 8 * BYTES_PER_WORD;

    // States in which the inter-byte idle timer runs: the ones waiting on
    // a byte inside a frame. WRITE waits on nothing; IDLE/DONE/ERR may idle forever.
    function automatic logic is_timed_state(input ld_state_e s);
        return (s == ST_COUNT) || (s == ST_LO) || (s == ST_HI) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_ld_timer.sv
// rtl/imem_ld_timer.sv - clear/enable idle counter with terminal-count flag
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-low reset
//   clr  in   clear count to zero (wins over en)
//   en   in   advance count by one this cycle
//   tc   out  count has reached TIMEOUT_CYC-1
module imem_ld_timer #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc = (count_q == TC_VAL);

    // Saturates at the terminal value so tc stays asserted until cleared.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to IMEM word writer with CPU hold
//
// Frame: SYNC_BYTE, N (0 means 2**ADDR_W), N x {lo, hi}, XOR checksum of data bytes.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-low reset
//   in_byte       in   received byte
//   in_valid      in   in_byte valid; transfer when in_valid && in_ready
//   in_ready      out  loader accepts a byte (low only while writing a word)
//   mem_addr      out  IMEM write address
//   mem_wdata     out  IMEM write data {hi, lo}
//   mem_we        out  IMEM write enable, one pulse per word
//   cpu_hold      out  1 keeps the cores in reset
//   load_done     out  last frame loaded with good checksum
//   load_err      out  last frame failed (checksum or timeout)
//   words_loaded  out  words written in the current/last frame
module imem_loader
    import imem_ld_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter int         DATA_W      = DATA_W_DEF,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] FULL_N = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_W  = (ADDR_W + 1)'(1);

    ld_state_e         state_q,        state_d;
    logic [ADDR_W:0]   n_q,            n_d;
    logic [ADDR_W:0]   idx_q,          idx_d;
    logic [7:0]        acc_q,          acc_d;
    logic [7:0]        lo_q,           lo_d;
    logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,    mem_wdata_d;
    logic              mem_we_q,       mem_we_d;
    logic              cpu_hold_q,     cpu_hold_d;
    logic              load_done_q,    load_done_d;
    logic              load_err_q,     load_err_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

    logic accept;
    logic is_sync;
    logic tmo;
    logic go_count;
    logic go_err;

    assign in_ready = (state_q != ST_WRITE);
    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_byte == SYNC_BYTE);

    imem_ld_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (is_timed_state(state_q)),
        .tc  (tmo)
    );

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        lo_d           = lo_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_we_d       = 1'b0;
        cpu_hold_d     = cpu_hold_q;
        load_done_d    = load_done_q;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;
        go_count       = 1'b0;
        go_err         = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // Non-SYNC bytes are consumed and dropped here.
                if (accept && is_sync) begin
                    go_count = 1'b1;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    n_d     = (in_byte == 8'h00) ? FULL_N : (ADDR_W + 1)'(in_byte);
                    state_d = ST_LO;
                end else if (tmo) begin
                    go_err = 1'b1;
                end
            end
            ST_LO: begin
                if (accept) begin
                    lo_d    = in_byte;
                    acc_d   = acc_q ^ in_byte;
                    state_d = ST_HI;
                end else if (tmo) begin
                    go_err = 1'b1;
                end
            end
            ST_HI: begin
                if (accept) begin
                    acc_d       = acc_q ^ in_byte;
                    mem_wdata_d = {in_byte, lo_q};
                    mem_addr_d  = idx_q[ADDR_W-1:0];
                    mem_we_d    = 1'b1;
                    state_d     = ST_WRITE;
                end else if (tmo) begin
                    go_err = 1'b1;
                end
            end
            ST_WRITE: begin
                // mem_we is high during this cycle; index is wide enough that
                // N = 2**ADDR_W terminates without wrapping back to address 0.
                idx_d          = idx_q + ONE_W;
                words_loaded_d = words_loaded_q + ONE_W;
                state_d        = ((idx_q + ONE_W) == n_q) ? ST_CSUM : ST_LO;
            end
            ST_CSUM: begin
                if (accept) begin
                    if (in_byte == acc_q) begin
                        state_d     = ST_DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        go_err = 1'b1;
                    end
                end else if (tmo) begin
                    go_err = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_count) begin
            state_d        = ST_COUNT;
            cpu_hold_d     = 1'b1;
            load_done_d    = 1'b0;
            load_err_d     = 1'b0;
            idx_d          = '0;
            acc_d          = '0;
            words_loaded_d = '0;
        end

        if (go_err) begin
            state_d     = ST_ERR;
            load_err_d  = 1'b1;
            load_done_d = 1'b0;
            cpu_hold_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            n_q            <= '0;
            idx_q          <= '0;
            acc_q          <= '0;
            lo_q           <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_we_q       <= 1'b0;
            cpu_hold_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            lo_q           <= lo_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_we_q       <= mem_we_d;
            cpu_hold_q     <= cpu_hold_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule
